adc_sample_reader: RTL
======================

Name: adc_sample_reader

Overview:
- Data-side reader for the ADC0820 breakout running in WR-RD standalone mode. CS_n and RD_n are tied low; WR_n comes from the WR pulse generator.
- Observes the conversion-start strobe (wr_n) and the ADC end-of-conversion flag (int_n), then captures DB[7:0] once the data has settled.
- Presents each result as a registered byte with a one-cycle valid pulse for downstream logic (voltmeter scaling/display).
- Flags conversions that never complete and conversions that are restarted before capture.

Parameters:
- DATA_W, 8, ADC data bus width.
- SETTLE_CYCLES, 1, clk cycles to wait after synchronized int_n low before sampling db (range 1..15).
- TIMEOUT_CYCLES, 64, max clk cycles in CONVERT before timeout (range 4..255). 64 is about 31 us at 2.08 MHz.

Ports:
- clk, input, 1, system clock, 2.08 MHz nominal.
- reset_n, input, 1, asynchronous active-low reset.
- wr_n, input, 1, ADC WR_n strobe; its rising edge starts a conversion.
- int_n, input, 1, ADC INT_n; low means the result is ready. Asynchronous to clk.
- db, input, DATA_W, ADC data bus. Stable while int_n is low.
- sample, output, DATA_W, last captured result.
- sample_valid, output, 1, one-cycle pulse when sample updates.
- timeout_err, output, 1, one-cycle pulse when a conversion times out.
- overrun_err, output, 1, one-cycle pulse when a new wr_n rise arrives before capture.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - sample = 0; sample_valid, timeout_err, overrun_err = 0.
  - State = IDLE; counters = 0.
  - Synchronizer flops = 1 (idle-high lines).
- Input synchronization:
  - wr_n and int_n each pass through 2 flops, giving wr_s and int_s.
  - wr_rise = wr_s high while its previous registered value was low.
  - db is not synchronized. It is registered only in the capture cycle; the int_n sync delay plus SETTLE_CYCLES guarantees it is stable.
- State machine (registered):
  - IDLE: on wr_rise go to CONVERT and clear cnt.
  - CONVERT:
    - int_s == 0: go to SETTLE and clear cnt.
    - Else if cnt == TIMEOUT_CYCLES-1: pulse timeout_err, go to IDLE.
    - Else cnt++.
  - SETTLE: cnt++. When cnt == SETTLE_CYCLES-1, sample <= db, pulse sample_valid next cycle, go to IDLE.
  - wr_rise while in CONVERT or SETTLE: pulse overrun_err, go to CONVERT with cnt cleared. Restart takes priority over timeout and capture in the same cycle.
- Latency:
  - int_n first sampled low at edge T0 gives sample_valid high in the cycle after edge T0+3+SETTLE_CYCLES.
  - wr_n rise sampled at edge W0 gives state CONVERT after edge W0+3.
- Boundaries:
  - int_n already low when CONVERT is entered: go to SETTLE on the first CONVERT cycle, which is legal.
  - int_n returning high during SETTLE: ignored; capture still occurs.
  - Outputs never assert together except overrun_err. overrun_err replaces, never accompanies, sample_valid for that cycle.
  - Counter width = clog2(TIMEOUT_CYCLES). There is no wrap, because compare-and-exit happens first.
  - Reset mid-conversion: immediate return to IDLE and all outputs 0. No sample_valid follows release.

Optional Feature:
- Macro: ADC_AVG_EN.
- Defined:
  - Adds outputs avg (DATA_W) and avg_valid (1).
  - A DATA_W+2 accumulator sums 4 consecutive captured samples. On the 4th sample, avg <= sum>>2 (truncate), avg_valid pulses in the same cycle as that sample_valid, and the accumulator clears.
  - timeout_err or overrun_err clears the accumulator and the sample count.
  - Reset values: avg = 0, avg_valid = 0.
- Undefined: ports absent; no accumulator logic.

Decomposition:
- Package adc_pkg holds:
  - State enum typedef (IDLE, CONVERT, SETTLE).
  - ADC_DATA_W = 8.
  - Default SETTLE/TIMEOUT constants.
  - AVG_DEPTH = 4.
- Sub-module sync_2ff (1-bit, reset-to-1 synchronizer), instantiated once each for wr_n and int_n.

Test Plan:
- Normal conversion: reset, wr_n low 20 cycles then high; int_n low 4 cycles after the rise; db = 8'hA5 -> sample_valid pulses once, sample = 8'hA5, no error pulses.
- Timeout: wr_n rise, int_n held high -> timeout_err pulses exactly once, 64 cycles after CONVERT entry; sample unchanged; state returns to IDLE.
- Overrun: wr_n rise, second wr_n rise 3 cycles later with int_n high -> overrun_err pulse; the following int_n low with db = 8'h3C gives sample = 8'h3C.
- Reset mid-operation: assert reset_n low during SETTLE -> all outputs 0 asynchronously; after release, no sample_valid without a new wr_n rise.
- Settle timing: SETTLE_CYCLES = 3, int_n falls at edge T0 -> sample_valid exactly in the cycle after edge T0+6; db changed at T0+7 is not captured.
- ADC_AVG_EN: samples 10, 20, 30, 41 -> avg = 25 with avg_valid on the 4th sample_valid; a timeout after 2 samples restarts the count.

Source files
------------

// File: rtl/adc_sample_reader_pkg.sv
`default_nettype none
// ============================================================================
// adc_pkg : shared types and constants for the ADC0820 sample reader
// Rev 1.0 - initial release
// ============================================================================
package adc_pkg;

  localparam int ADC_DATA_W         = 8;
  localparam int DEF_SETTLE_CYCLES  = 1;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int AVG_DEPTH          = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SETTLE  = 2'd2
  } adc_state_t;

  // The shared counter must reach both the timeout and the settle terminal count.
  function automatic int cnt_width(input int timeout_cycles, input int settle_cycles);
    int m;
    m = (timeout_cycles > settle_cycles) ? timeout_cycles : settle_cycles;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sample_reader_sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : 1-bit two-flop synchronizer, resets to 1 for idle-high lines
// Rev 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/adc_sample_reader.sv
`default_nettype none
// ============================================================================
// adc_sample_reader : WR-RD mode ADC0820 result capture with error flags.
// Optional 4-sample averager enabled by macro ADC_AVG_EN.
// Rev 1.0 - initial release
// ============================================================================
module adc_sample_reader
  import adc_pkg::*;
#(
  parameter int DATA_W         = ADC_DATA_W,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_n,
  input  logic              int_n,
  input  logic [DATA_W-1:0] db,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              timeout_err,
  output logic              overrun_err
`ifdef ADC_AVG_EN
  ,
  output logic [DATA_W-1:0] avg,
  output logic              avg_valid
`endif
);

  localparam int              c_cnt_w   = cnt_width(TIMEOUT_CYCLES, SETTLE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_st_last = c_cnt_w'(SETTLE_CYCLES - 1);

  logic               w_wr_s;
  logic               w_int_s;
  logic               r_wr_prev;
  logic               r_wr_rise;
  adc_state_t         r_state;
  adc_state_t         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_capture;
  logic               w_timeout;
  logic               w_overrun;
  logic               r_valid_pend;

  sync_2ff u_sync_wr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (wr_n),
    .o_q     (w_wr_s)
  );

  sync_2ff u_sync_int (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (int_n),
    .o_q     (w_int_s)
  );

  // Edge detect is registered so the FSM acts on a clean one-cycle strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_prev <= 1'b1;
      r_wr_rise <= 1'b0;
    end else begin
      r_wr_prev <= w_wr_s;
      r_wr_rise <= w_wr_s & ~r_wr_prev;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_wr_rise) begin
          w_state_nxt = CONVERT;
          w_cnt_nxt   = '0;
        end
      end
      CONVERT: begin
        if (r_wr_rise) begin
          w_overrun   = 1'b1;
          w_cnt_nxt   = '0;
        end else if (!w_int_s) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_to_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_w'(1);
        end
      end
      SETTLE: begin
        if (r_wr_rise) begin
          w_overrun   = 1'b1;
          w_state_nxt = CONVERT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_st_last) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_w'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The valid strobe trails the data register by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      sample       <= '0;
      r_valid_pend <= 1'b0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_valid_pend <= w_capture;
      sample_valid <= r_valid_pend;
      timeout_err  <= w_timeout;
      overrun_err  <= w_overrun;
      if (w_capture) begin
        sample <= db;
      end
    end
  end

`ifdef ADC_AVG_EN
  localparam int c_avg_cw = $clog2(AVG_DEPTH);

  logic [DATA_W+1:0]   r_acc;
  logic [c_avg_cw-1:0] r_avg_cnt;
  logic [DATA_W+1:0]   w_acc_sum;

  assign w_acc_sum = r_acc + {2'b00, sample};

  // Accumulates while the fresh sample sits in the register, so avg_valid
  // lines up with the sample_valid of the final sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc     <= '0;
      r_avg_cnt <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (w_timeout || w_overrun) begin
        r_acc     <= '0;
        r_avg_cnt <= '0;
      end else if (r_valid_pend) begin
        if (r_avg_cnt == c_avg_cw'(AVG_DEPTH - 1)) begin
          avg       <= w_acc_sum[DATA_W+1:2];
          avg_valid <= 1'b1;
          r_acc     <= '0;
          r_avg_cnt <= '0;
        end else begin
          r_acc     <= w_acc_sum;
          r_avg_cnt <= r_avg_cnt + c_avg_cw'(1);
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire
